// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered IN_W -> 2^IN_W one-hot decoder with an
// in_valid/in_ready handshake, enable gating, optional active-low output
// polarity and an autonomous SCAN mode. SCAN walks the asserted line
// through every output, holding each line for a programmable dwell.
//
// Latency: an accepted transfer shows up on out/idx/out_valid one cycle later.
// Backpressure: in_ready = en & (state != SCAN). A transfer happens only
// when in_valid, in_ready and en are all high.
//
// Ports:
//   clk, rst   rising-edge clock; synchronous active-high reset
//   en         block enable; low forces a return to IDLE
//   in_valid   select transfer request
//   in_ready   transfer can be accepted (combinational)
//   in_sel     line to assert (DIRECT) or first line (SCAN)
//   mode       0 = DIRECT, 1 = SCAN; sampled with the transfer
//   dwell      SCAN hold length minus one; sampled at each reload
//   out        registered one-hot select lines (inverted if ACTIVE_LOW)
//   out_valid  a line is asserted
//   idx        index of the asserted line
//   wrap       one-cycle pulse when SCAN steps from the last line to line 0
module onehot_decoder_seq #(
  parameter int unsigned IN_W       = 2,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_sel,
  input  logic                  mode,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<IN_W)-1:0]  out,
  output logic                  out_valid,
  output logic [IN_W-1:0]       idx,
  output logic                  wrap
);

  localparam int unsigned OUT_W = 1 << IN_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SCAN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               vld_q, vld_d;
  logic               xfer;

  // SCAN owns the outputs; no new selection is accepted while it runs.
  assign in_ready = en & (state_q != S_SCAN);
  assign xfer     = in_valid & in_ready;

  // State register; every visible output except in_ready is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= {OUT_W{ACTIVE_LOW}};
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  // Next state. Order encodes priority: disable, then transfer, then scan step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (xfer) begin
      state_d = mode ? S_SCAN : S_HOLD;
      idx_d   = in_sel;
      cnt_d   = mode ? dwell : '0;
    end else if (state_q == S_SCAN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        // idx rolls over modulo OUT_W by its width alone.
        idx_d  = idx_q + 1'b1;
        cnt_d  = dwell;
        // Stepping off the all-ones index lands on line 0.
        wrap_d = &idx_q;
      end
    end
  end

  // Output decode from the next state so out lines up with idx/out_valid.
  always_comb begin
    out_d = '0;
    vld_d = (state_d != S_IDLE);
    if (vld_d) begin
      out_d[idx_d] = 1'b1;
    end
    if (ACTIVE_LOW) begin
      out_d = ~out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Parametrised, registered IN_W-to-2^IN_W one-hot decoder. It is the successor to the team's fixed 2-to-4 combinational decoder. It adds a valid/ready input handshake, enable gating, optional active-low outputs, and an autonomous SCAN mode. SCAN walks the one-hot output through every line with a programmable dwell, for strobe/row-select generation. It sits between control logic and peripheral select lines.

Parameters:
IN_W, 2, select width; output width OUT_W = 2^IN_W (IN_W range 1..6)
DWELL_W, 8, width of dwell counter/input
ACTIVE_LOW, 0, 1 = output lines inverted (asserted line = 0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  block enable; low forces return to IDLE
in_valid  input  1  select transfer request
in_ready  output  1  accept indication; transfer occurs when in_valid & in_ready & en
in_sel  input  IN_W  line to assert (DIRECT) or start line (SCAN)
mode  input  1  sampled with transfer: 0 = DIRECT, 1 = SCAN
dwell  input  DWELL_W  SCAN hold length minus one; sampled at each reload
out  output  OUT_W  registered one-hot select lines (polarity per ACTIVE_LOW)
out_valid  output  1  high when any line asserted (state != IDLE)
idx  output  IN_W  index of currently asserted line
wrap  output  1  one-cycle pulse when SCAN wraps from OUT_W-1 to 0

Behaviour:
- Reset (sync, highest priority):
  - state = IDLE; out = all-inactive (0s, or 1s if ACTIVE_LOW); out_valid = 0; idx = 0; wrap = 0; dwell counter = 0.
  - Reset mid-SCAN aborts on the same edge.
- All outputs are registered except in_ready. in_ready = en & (state != SCAN).
- Latency: an accepted transfer at edge N gives the new out/idx/out_valid after edge N (one cycle).
- States:
  - IDLE: out inactive.
    - Transfer with mode=0 -> HOLD, out = onehot(in_sel), idx = in_sel.
    - Transfer with mode=1 -> SCAN, out = onehot(in_sel), idx = in_sel, cnt = dwell.
  - HOLD: out held indefinitely.
    - New transfer replaces the selection next cycle. Back-to-back transfers every cycle are legal.
    - A mode=1 transfer enters SCAN from in_sel.
    - en=0 -> IDLE; out inactive next cycle.
  - SCAN: in_ready=0; in_valid is ignored.
    - Each cycle, if cnt != 0 then cnt decrements.
    - If cnt == 0: idx = (idx+1) mod OUT_W, out rotates left by one, cnt reloads from the current dwell.
    - Each line is therefore asserted for dwell+1 cycles. dwell=0 steps every cycle.
    - wrap = 1 exactly in the cycle where out first shows line 0 after a step from line OUT_W-1. It never asserts on SCAN entry, even if in_sel = 0.
    - en=0 -> IDLE; out inactive and out_valid = 0 next cycle; cnt cleared.
- Priority: rst > en=0 > transfer > SCAN step.
- Exactly one line is asserted whenever out_valid=1. No line is asserted when out_valid=0.
- ACTIVE_LOW inverts only out. idx, out_valid and wrap are unaffected.
- Arithmetic: idx wraps modulo 2^IN_W naturally. cnt is DWELL_W bits and never underflows.

Test Plan:
- DIRECT, IN_W=2: transfers of in_sel = 0,1,2,3 on consecutive cycles -> out = 0001, 0010, 0100, 1000, each one cycle after its transfer, out_valid = 1 throughout.
- SCAN, dwell=2, in_sel=2, IN_W=2 -> out 0100 x3 cycles, 1000 x3, 0001 x3 with wrap = 1 only in the first 0001 cycle, then 0010; in_ready = 0 and an in_valid pulse is ignored.
- SCAN, dwell=0 -> line advances every cycle. Dropping en while out = 1000 -> next cycle out = 0000, out_valid = 0, in_ready = 0 until en returns.
- Reset asserted mid-SCAN -> next cycle out = 0000, idx = 0, wrap = 0. First transfer after reset decodes normally.
- Instance with IN_W=3, ACTIVE_LOW=1: reset -> out = 0xFF; DIRECT in_sel = 5 -> out = 0xDF, idx = 5.
- HOLD at in_sel = 1, then a mode=1 transfer with in_sel = 3, dwell = 1 in the same cycle that en drops -> en wins: IDLE, out inactive, no scan started.
